// File: rtl/core_lsu_pkg.sv
// rtl/core_lsu_pkg.sv - shared state and access-size definitions for the load/store controller
package core_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [3:0] SIZE_BYTE = 4'b0001;
    localparam logic [3:0] SIZE_HALF = 4'b0011;
    localparam logic [3:0] SIZE_WORD = 4'b1111;

endpackage

// File: rtl/core_lsu_align.sv
// rtl/core_lsu_align.sv - byte enables, store lane replication and alignment check
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [3:0]  d_size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned
);

    // Unknown size codes fall into the word branch.
    always_comb begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = 1'b0;
        case (d_size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/core_lsu_ctrl.sv
// rtl/core_lsu_ctrl.sv - single-outstanding load/store controller between MEM stage and data bus
module core_lsu_ctrl
    import core_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mem_valid,
    input  logic            i_mem_we,
    input  logic [3:0]      i_d_size,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_misaligned,
    output logic            o_bus_err,
    output logic            o_rd_valid,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_data_req,
    output logic            o_data_we,
    output logic [3:0]      o_data_be,
    output logic [XLEN-1:0] o_data_addr,
    output logic [XLEN-1:0] o_data_wdata,
    input  logic            i_data_gnt,
    input  logic            i_data_rvalid,
    input  logic [XLEN-1:0] i_data_rdata,
    input  logic            i_data_err
);

    lsu_state_t      state;
    logic [7:0]      tmo_cnt;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic            mis_c;
    logic            accept;
    logic            tmo_hit;

    core_lsu_align u_align (
        .d_size     (i_d_size),
        .addr_lo    (i_addr[1:0]),
        .wdata      (i_wdata),
        .be         (be_c),
        .wdata_rep  (wdata_c),
        .misaligned (mis_c)
    );

    assign accept       = (state == IDLE) && i_mem_valid && !mis_c;
    assign o_misaligned = (state == IDLE) && i_mem_valid && mis_c;
    assign o_stall      = accept || (state == REQ) || (state == WAIT);
    // The counter tallies completed REQ/WAIT cycles, so this is the last one allowed.
    assign tmo_hit      = (tmo_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            tmo_cnt      <= 8'd0;
            o_data_req   <= 1'b0;
            o_data_we    <= 1'b0;
            o_data_be    <= 4'd0;
            o_data_addr  <= '0;
            o_data_wdata <= '0;
            o_rd_valid   <= 1'b0;
            o_bus_err    <= 1'b0;
            o_rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt    <= 8'd0;
                    o_rd_valid <= 1'b0;
                    o_bus_err  <= 1'b0;
                    if (accept) begin
                        state        <= REQ;
                        o_data_req   <= 1'b1;
                        o_data_we    <= i_mem_we;
                        o_data_be    <= be_c;
                        o_data_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_data_wdata <= wdata_c;
                    end
                end
                REQ: begin
                    if (tmo_hit) begin
                        state      <= RESP;
                        o_data_req <= 1'b0;
                        o_rd_valid <= 1'b1;
                        o_bus_err  <= 1'b1;
                        o_rd_data  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (i_data_gnt) begin
                            state      <= WAIT;
                            o_data_req <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the final allowed cycle still wins over the timeout.
                    if (i_data_rvalid) begin
                        state      <= RESP;
                        o_rd_valid <= 1'b1;
                        o_bus_err  <= i_data_err;
                        o_rd_data  <= i_data_rdata;
                    end else if (tmo_hit) begin
                        state      <= RESP;
                        o_rd_valid <= 1'b1;
                        o_bus_err  <= 1'b1;
                        o_rd_data  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    o_rd_valid <= 1'b0;
                    o_bus_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb/tb_core_lsu_ctrl.sv - directed and randomized checks of core_lsu_ctrl against a behavioural model
module tb_core_lsu_ctrl;

    localparam int TMO = 8;

    logic        i_clk;
    logic        i_rst;
    logic        i_mem_valid;
    logic        i_mem_we;
    logic [3:0]  i_d_size;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_err;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_data_req;
    logic        o_data_we;
    logic [3:0]  o_data_be;
    logic [31:0] o_data_addr;
    logic [31:0] o_data_wdata;
    logic        i_data_gnt;
    logic        i_data_rvalid;
    logic [31:0] i_data_rdata;
    logic        i_data_err;

    core_lsu_ctrl #(.XLEN(32), .TIMEOUT(TMO)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_mem_valid   (i_mem_valid),
        .i_mem_we      (i_mem_we),
        .i_d_size      (i_d_size),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_stall       (o_stall),
        .o_misaligned  (o_misaligned),
        .o_bus_err     (o_bus_err),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_data_req    (o_data_req),
        .o_data_we     (o_data_we),
        .o_data_be     (o_data_be),
        .o_data_addr   (o_data_addr),
        .o_data_wdata  (o_data_wdata),
        .i_data_gnt    (i_data_gnt),
        .i_data_rvalid (i_data_rvalid),
        .i_data_rdata  (i_data_rdata),
        .i_data_err    (i_data_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    // Model: one operation in flight, tracked as "waiting for grant", "waiting for response", "reporting".
    bit          m_req, m_wait, m_resp;
    int          m_spent;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_err;
    bit          drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit size_is(input logic [3:0] s, input logic [3:0] v);
        return s == v;
    endfunction

    function automatic bit exp_mis(input logic [3:0] s, input logic [31:0] a);
        if (size_is(s, 4'b0001)) return 1'b0;
        if (size_is(s, 4'b0011)) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] s, input logic [31:0] a);
        int lane;
        lane = int'(a % 4);
        if (size_is(s, 4'b0001)) return 4'(1 << lane);
        if (size_is(s, 4'b0011)) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wrep(input logic [3:0] s, input logic [31:0] d);
        if (size_is(s, 4'b0001)) return 32'h01010101 * (d & 32'hFF);
        if (size_is(s, 4'b0011)) return 32'h00010001 * (d & 32'hFFFF);
        return d;
    endfunction

    task automatic model_reset();
        m_req = 0; m_wait = 0; m_resp = 0; m_spent = 0;
    endtask

    task automatic model_finish(input logic err, input logic [31:0] data);
        m_req = 0; m_wait = 0; m_resp = 1;
        e_err = err; e_rdata = data;
    endtask

    task automatic model_step();
        if (m_resp) begin
            m_resp = 0;
        end else if (m_req || m_wait) begin
            m_spent++;
            if (m_wait && i_data_rvalid) model_finish(i_data_err, i_data_rdata);
            else if (m_spent == TMO) model_finish(1'b1, 32'd0);
            else if (m_req && i_data_gnt) begin
                m_req = 0; m_wait = 1;
            end
        end else if (i_mem_valid && !exp_mis(i_d_size, i_addr)) begin
            m_req   = 1;
            m_spent = 0;
            e_we    = i_mem_we;
            e_be    = exp_be(i_d_size, i_addr);
            e_addr  = i_addr & 32'hFFFF_FFFC;
            e_wdata = exp_wrep(i_d_size, i_wdata);
        end
    endtask

    task automatic compare();
        bit idle, mis;
        idle = !(m_req || m_wait || m_resp);
        mis  = exp_mis(i_d_size, i_addr);
        check("stall", o_stall, (idle && i_mem_valid && !mis) || m_req || m_wait);
        check("misaligned", o_misaligned, idle && i_mem_valid && mis);
        check("data_req", o_data_req, m_req);
        check("rd_valid", o_rd_valid, m_resp);
        check("bus_err", o_bus_err, m_resp ? e_err : 1'b0);
        if (m_resp) check("rd_data", o_rd_data, e_rdata);
        if (m_req) begin
            check("data_we", o_data_we, e_we);
            check("data_be", o_data_be, e_be);
            check("data_addr", o_data_addr, e_addr);
            check("data_wdata", o_data_wdata, e_wdata);
        end
    endtask

    task automatic cycle();
        #1;
        compare();
        if (o_stall) stall_cnt++;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic set_op(input logic v, input logic we, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        i_mem_valid = v; i_mem_we = we; i_d_size = s; i_addr = a; i_wdata = d;
    endtask

    task automatic set_bus(input logic g, input logic rv, input logic [31:0] rd, input logic er);
        i_data_gnt = g; i_data_rvalid = rv; i_data_rdata = rd; i_data_err = er;
    endtask

    task automatic async_reset(input string name);
        #2;
        i_rst = 1'b1;
        i_mem_valid = 1'b0;
        #1;
        check({name, "_req"}, o_data_req, 1'b0);
        check({name, "_stall"}, o_stall, 1'b0);
        check({name, "_rd_valid"}, o_rd_valid, 1'b0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        i_clk = 0;
        i_rst = 1;
        set_op(0, 0, 4'hF, 0, 0);
        set_bus(0, 0, 0, 0);
        model_reset();
        @(negedge i_clk);
        #1;
        check("rst_addr", o_data_addr, 32'd0);
        check("rst_be", o_data_be, 4'd0);
        check("rst_wdata", o_data_wdata, 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);
        compare();
        i_rst = 0;
        @(negedge i_clk);

        // Best-case word load.
        stall_cnt = 0;
        set_op(1, 0, 4'hF, 32'h100, 0);
        cycle();
        set_bus(1, 0, 0, 0);
        #1;
        check("t1_addr", o_data_addr, 32'h100);
        check("t1_be", o_data_be, 4'b1111);
        check("t1_we", o_data_we, 1'b0);
        cycle();
        set_bus(0, 1, 32'hDEADBEEF, 0);
        cycle();
        set_bus(0, 0, 0, 0);
        #1;
        check("t1_rd_valid", o_rd_valid, 1'b1);
        check("t1_rd_data", o_rd_data, 32'hDEADBEEF);
        cycle();
        set_op(0, 0, 4'hF, 0, 0);
        cycle();
        check("t1_stall_cycles", stall_cnt, 3);

        // Byte store at 0x203.
        set_op(1, 1, 4'b0001, 32'h203, 32'h000000A5);
        cycle();
        set_op(0, 0, 4'hF, 0, 0);
        set_bus(1, 0, 0, 0);
        #1;
        check("t2_be", o_data_be, 4'b1000);
        check("t2_wdata", o_data_wdata, 32'hA5A5A5A5);
        check("t2_addr", o_data_addr, 32'h200);
        cycle();
        set_bus(0, 1, 32'h0, 0);
        cycle();
        set_bus(0, 0, 0, 0);
        cycle();

        // Half load at 0x102, then the two misaligned cases.
        set_op(1, 0, 4'b0011, 32'h102, 0);
        cycle();
        set_op(0, 0, 4'hF, 0, 0);
        #1;
        check("t3_be", o_data_be, 4'b1100);
        set_bus(1, 0, 0, 0);
        cycle();
        set_bus(0, 1, 32'h5555AAAA, 0);
        cycle();
        set_bus(0, 0, 0, 0);
        cycle();
        set_op(1, 0, 4'b0011, 32'h101, 0);
        #1;
        check("t3_mis_half", o_misaligned, 1'b1);
        check("t3_mis_half_stall", o_stall, 1'b0);
        cycle();
        check("t3_mis_half_req", o_data_req, 1'b0);
        set_op(1, 0, 4'b1111, 32'h102, 0);
        #1;
        check("t3_mis_word", o_misaligned, 1'b1);
        check("t3_mis_word_stall", o_stall, 1'b0);
        cycle();
        check("t3_mis_word_req", o_data_req, 1'b0);

        // Grant delayed 4 cycles, then an error response.
        set_op(1, 1, 4'hF, 32'h300, 32'h12345678);
        cycle();
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t4_req_held", o_data_req, 1'b1);
            check("t4_addr_held", o_data_addr, 32'h300);
            check("t4_wdata_held", o_data_wdata, 32'h12345678);
            check("t4_stall_held", o_stall, 1'b1);
            cycle();
        end
        set_bus(1, 0, 0, 0);
        cycle();
        set_bus(0, 1, 32'hCAFE0001, 1);
        cycle();
        set_bus(0, 0, 0, 0);
        #1;
        check("t5_rd_valid", o_rd_valid, 1'b1);
        check("t5_bus_err", o_bus_err, 1'b1);
        cycle();
        set_op(0, 0, 4'hF, 0, 0);
        cycle();

        // Timeout: grant but no response.
        set_op(1, 0, 4'hF, 32'h400, 0);
        cycle();
        set_op(0, 0, 4'hF, 0, 0);
        for (int k = 1; k <= TMO; k++) begin
            set_bus(k == 1, 0, 0, 0);
            #1;
            check("t6_no_early_resp", o_rd_valid, 1'b0);
            cycle();
        end
        set_bus(0, 0, 0, 0);
        #1;
        check("t6_tmo_valid", o_rd_valid, 1'b1);
        check("t6_tmo_err", o_bus_err, 1'b1);
        check("t6_tmo_data", o_rd_data, 32'd0);
        set_bus(0, 1, 32'h77777777, 0);
        cycle();
        cycle();
        set_bus(0, 0, 0, 0);

        // Reset asserted while in REQ and while in WAIT.
        set_op(1, 0, 4'hF, 32'h500, 0);
        cycle();
        async_reset("t7_rst_req");
        set_op(1, 0, 4'hF, 32'h600, 0);
        cycle();
        set_bus(1, 0, 0, 0);
        cycle();
        set_bus(0, 0, 0, 0);
        cycle();
        async_reset("t7_rst_wait");
        set_bus(0, 1, 32'h99999999, 0);
        cycle();
        set_bus(0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if (!(m_req || m_wait || m_resp)) begin
                logic [3:0] sz;
                case ($urandom % 5)
                    0: sz = 4'b0001;
                    1: sz = 4'b0011;
                    2: sz = 4'b1111;
                    default: sz = 4'($urandom);
                endcase
                set_op(($urandom % 10) < 7, 1'($urandom), sz, $urandom, $urandom);
                drop = ($urandom % 6) == 0;
            end
            i_data_gnt    = m_req ? 1'($urandom) : (($urandom % 10) == 0);
            i_data_rvalid = (m_wait && !drop) ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            i_data_err    = ($urandom % 5) == 0;
            i_data_rdata  = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
